// File: rtl/md5_pkg.sv
// Shared constants and FSM encoding for the MD5 digest I/O blocks.
package md5_pkg;

    localparam int unsigned DIGEST_BYTES = 16;
    localparam int unsigned DIGEST_W     = 128;

    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;

endpackage

// File: rtl/md5_nib2ascii.sv
// 4-bit nibble to lowercase ASCII hex character, purely combinational.
module md5_nib2ascii
    import md5_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] asc_o
);

    always_comb begin
        if (nib_i < 4'd10) asc_o = ASCII_0 + {4'h0, nib_i};
        else               asc_o = ASCII_A_LC + {4'h0, nib_i} - 8'd10;
    end

endmodule

// File: rtl/md5_digest_tx.sv
// Serialises one 128-bit MD5 digest into a byte stream, raw or lowercase hex,
// with an optional trailing newline. Every output is driven from a register.
module md5_digest_tx
    import md5_pkg::*;
#(
    parameter bit HEX_MODE  = 1'b1,
    parameter bit APPEND_NL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dig_valid,
    output logic                dig_ready,
    input  logic [DIGEST_W-1:0] dig_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_last,
    output logic                busy
);

    localparam int unsigned N        = (HEX_MODE ? 2 * DIGEST_BYTES : DIGEST_BYTES)
                                       + (APPEND_NL ? 1 : 0);
    localparam logic [5:0]  LAST_IDX = 6'(N - 1);

    tx_state_e           state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DIGEST_W-1:0] dig_q, dig_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_last_q, tx_last_d;
    logic                dig_ready_q, dig_ready_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic [DIGEST_W-1:0] src;
    logic [5:0]          idx;
    logic [3:0]          byte_idx;
    logic [7:0]          src_byte;
    logic [3:0]          nib;
    logic [7:0]          nib_asc;
    logic [7:0]          sel_byte;

    // The byte being loaded into tx_data_q: byte 0 of the incoming digest on
    // acceptance, otherwise the byte after the current one.
    always_comb begin
        accept   = (state_q == IDLE) && dig_valid && dig_ready_q;
        src      = accept ? dig_data : dig_q;
        idx      = accept ? 6'd0 : cnt_q + 6'd1;
        byte_idx = HEX_MODE ? idx[4:1] : idx[3:0];
        src_byte = src[{byte_idx, 3'b000} +: 8];
        nib      = idx[0] ? src_byte[3:0] : src_byte[7:4];
    end

    md5_nib2ascii u_nib2ascii (
        .nib_i (nib),
        .asc_o (nib_asc)
    );

    always_comb begin
        if (APPEND_NL && idx == LAST_IDX) sel_byte = ASCII_NL;
        else if (HEX_MODE)                sel_byte = nib_asc;
        else                              sel_byte = src_byte;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        tx_last_d   = tx_last_q;
        dig_ready_d = dig_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                dig_ready_d = 1'b1;
                if (accept) begin
                    state_d     = SEND;
                    dig_d       = dig_data;
                    cnt_d       = 6'd0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = sel_byte;
                    tx_last_d   = (idx == LAST_IDX);
                    dig_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (tx_last_q) begin
                        state_d     = IDLE;
                        tx_valid_d  = 1'b0;
                        tx_data_d   = 8'h00;
                        tx_last_d   = 1'b0;
                        dig_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        cnt_d     = idx;
                        tx_data_d = sel_byte;
                        tx_last_d = (idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            dig_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_last_q   <= 1'b0;
            dig_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_last_q   <= tx_last_d;
            dig_ready_q <= dig_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign dig_ready = dig_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_last   = tx_last_q;
    assign busy      = busy_q;

endmodule

// File: doc/md5_digest_tx.md
Name: md5_digest_tx

Overview:
- Output end of the MD5 core. Accepts one finished 128-bit digest from `md5_core` over a valid/ready handshake.
- Streams the digest out as a byte stream (valid/ready, with last-byte marker) toward the host UART/FIFO.
- The byte stream carries either raw binary bytes or lowercase ASCII hex, with an optional newline terminator.
- Together with the message-block loader, it forms the FPGA hashing datapath's I/O pair.

Parameters:
- HEX_MODE, 1: 1 = emit 32 lowercase ASCII hex chars; 0 = emit 16 raw bytes.
- APPEND_NL, 1: 1 = append 0x0A after the digest bytes/chars; 0 = no terminator.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- dig_valid  in  1  digest available from core.
- dig_ready  out  1  block can accept a digest.
- dig_data  in  128  digest; dig_data[7:0] = digest byte 0 (first byte of canonical MD5 output), dig_data[127:120] = byte 15.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts byte.
- tx_data  out  8  output byte.
- tx_last  out  1  high with final byte of this digest.
- busy  out  1  high while a digest is held or being sent.

Behaviour:
- Reset (rst_n=0 at a clk edge): dig_ready=0 in the reset cycle, 1 from the first cycle after reset is released. tx_valid=0, tx_data=0x00, tx_last=0, busy=0. Counter and digest register are cleared. A reset mid-transfer discards the remaining bytes; no tx_last is emitted.
- All outputs are registered; no combinational path from any input to any output.
- FSM states:
  - IDLE: dig_ready=1, tx_valid=0. On dig_valid&&dig_ready: latch dig_data, counter=0, go to SEND.
  - SEND: dig_ready=0, busy=1.
    - tx_valid rises the cycle after acceptance (latency 1).
    - tx_data/tx_last stay stable while tx_valid&&!tx_ready.
    - On tx_valid&&tx_ready: counter++ and the next byte is presented the following cycle, so full throughput is 1 byte/clk with tx_ready held high.
    - On the handshake of the byte with tx_last=1: go to IDLE. tx_valid=0 and dig_ready=1 next cycle (one bubble between digests).
- Byte count N = (HEX_MODE ? 32 : 16) + APPEND_NL. Counter width is 6 bits. tx_last = (counter == N-1).
- Binary mode: byte k (k<16) = digest byte k.
- Hex mode:
  - char k (k<32) = nibble of digest byte k>>1, with the high nibble first (k even → [7:4], k odd → [3:0]).
  - Nibble 0-9 → 0x30+n; 10-15 → 0x61+(n-10) (lowercase).
- Terminator (APPEND_NL=1): byte N-1 = 0x0A.
- dig_valid while in SEND is ignored. The core must hold dig_valid until dig_ready (standard rule).
- tx_ready toggling arbitrarily must never drop, repeat or reorder bytes.

Decomposition:
- md5_pkg holds:
  - DIGEST_BYTES=16, DIGEST_W=128.
  - ASCII_NL=8'h0A, ASCII_0=8'h30, ASCII_A_LC=8'h61.
  - FSM state encoding {IDLE, SEND}.
- One sub-module: md5_nib2ascii (4-bit nibble → 8-bit lowercase ASCII, purely combinational). It is reused by the debug display path.

Test Plan:
- Empty-string digest, HEX_MODE=1, APPEND_NL=1, tx_ready=1: dig_data bytes d4 1d 8c d9 8f 00 b2 04 e9 80 09 98 ec f8 42 7e (byte0 in [7:0]).
  - Required response: 33 bytes "d41d8cd98f00b204e9800998ecf8427e\n". First tx_data=0x64, second=0x34, byte 32=0x0A with tx_last=1.
  - Timing: tx_valid first high 1 cycle after acceptance; last byte 33 cycles after acceptance.
- Same digest, HEX_MODE=0, APPEND_NL=0: 16 bytes 0xd4…0x7e. tx_last only on 0x7e. dig_ready=1 the cycle after that handshake.
- Backpressure: tx_ready pattern 1,0,0,1,0,1… (random, 50%) → output sequence identical to the first scenario. tx_data/tx_last held stable on every stalled cycle. dig_ready stays 0 throughout.
- Back-to-back: second digest (all 0xFF) presented with dig_valid held high during the first transfer → not accepted until the IDLE cycle. Then "ffff…ff\n" (32×0x66, 0x0A) follows after exactly one idle cycle.
- Reset mid-operation: assert rst_n=0 after 10 hex chars sent → next cycle tx_valid=0, busy=0. dig_ready=1 from the first cycle after release. A fresh digest then restarts from char 0.
- Nibble coverage: digest bytes 0x01,0x23,0x45,0x67,0x89,0xab,0xcd,0xef (rest 0) → chars "0123456789abcdef" followed by 16×'0'. Checks both the 9→'9' and 10→'a' boundaries.
